// File: rtl/controle_pkg.sv
// Shared constants for the multicycle MIPS main control unit:
// state encodings, opcodes, ALUOp codes and the control-word layout.
package controle_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JR        = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // One bundle for every datapath control so it can be zeroed in one go.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/controle_saidas.sv
// Purely combinational state-to-control-word decoder (Moore outputs).
// Unused encodings and any signal not named for a state decode to 0.
module controle_saidas
    import controle_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = 2'b01;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = 2'b11;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = 2'b10;
            end
            S_ADDI_WB: o_ctrl.reg_write = 1'b1;
            S_JR: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = 2'b11;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/controle_principal_fsm.sv
// Multicycle MIPS main control FSM: sequences FETCH..WB and drives the
// datapath controls; all controls are held at 0 while reset is high.
module controle_principal_fsm
    import controle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl_dec;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_RTYPE:     w_next_state = (func == FUNC_JR) ? S_JR : S_R_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDI_EXEC;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      w_next_state = S_MEM_READ;
                else if (opcode == OP_SW) w_next_state = S_MEM_WRITE;
                else                      w_next_state = S_FETCH;
            end
            S_MEM_READ:  w_next_state = S_MEM_WB;
            S_R_EXEC:    w_next_state = S_R_WB;
            S_ADDI_EXEC: w_next_state = S_ADDI_WB;
            default:     w_next_state = S_FETCH;
        endcase
    end

    controle_saidas u_saidas (
        .i_state (r_state),
        .o_ctrl  (w_ctrl_dec)
    );

    // Gating with reset keeps every write strobe quiet during reset and on abort.
    assign w_ctrl = reset ? '0 : w_ctrl_dec;

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign state       = r_state;

endmodule

// File: tb/tb_controle_principal_fsm.sv
// Table-driven bench for controle_principal_fsm: per-cycle state and full
// control-word checks, plus cycle-count and strobe-count sequences.
module tb_controle_principal_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    controle_principal_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .func        (func),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
    // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rst);
        logic [15:0] w;
        w = 16'h0;
        if (!rst) begin
            case (st)
                4'd0:  w = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
                4'd1:  w = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00};
                4'd2:  w = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
                4'd3:  w = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
                4'd4:  w = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
                4'd5:  w = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
                4'd6:  w = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00};
                4'd7:  w = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00};
                4'd8:  w = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01};
                4'd9:  w = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10};
                4'd10: w = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
                4'd11: w = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
                4'd12: w = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11};
                default: w = 16'h0;
            endcase
        end
        return w;
    endfunction

    function automatic logic [15:0] act_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
    endfunction

    function automatic vec_t mk(input logic r, input logic [5:0] o,
                                input logic [5:0] f, input logic [3:0] s);
        vec_t v;
        v.rst = r; v.op = o; v.fn = f; v.st = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // driver: apply one cycle of inputs, check, then advance one edge
    task automatic step(input vec_t v, input int idx);
        reset = v.rst; opcode = v.op; func = v.fn;
        #1;
        check($sformatf("vec%0d_state", idx), {12'h0, state}, {12'h0, v.st});
        check($sformatf("vec%0d_ctrl", idx), act_ctrl(), exp_ctrl(v.st, v.rst));
        @(posedge clk);
        #1;
    endtask

    // run one instruction from FETCH; count cycles until FETCH returns
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int exp_cycles, input int exp_regw, input int exp_memw);
        int cyc, regw, memw, pcw;
        reset = 1'b0; opcode = op; func = fn;
        #1;
        check({name, "_start"}, {12'h0, state}, 16'd0);
        cyc = 0; regw = 0; memw = 0; pcw = 0;
        do begin
            regw += int'(RegWrite);
            memw += int'(MemWrite);
            pcw  += int'(PCWrite);
            @(posedge clk);
            #1;
            cyc++;
        end while (state != 4'd0 && cyc < 20);
        check({name, "_cycles"}, 16'(cyc), 16'(exp_cycles));
        check({name, "_regwrite"}, 16'(regw), 16'(exp_regw));
        check({name, "_memwrite"}, 16'(memw), 16'(exp_memw));
        check({name, "_pcwrite_min"}, 16'(pcw >= 1), 16'd1);
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h0; func = 6'h0;
        @(posedge clk);
        #1;

        // reset, then LW
        vecs.push_back(mk(1, 6'b100011, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd1));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd2));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd3));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd4));
        // R-type ADD, then JR
        vecs.push_back(mk(0, 6'b000000, 6'b100000, 4'd0));
        vecs.push_back(mk(0, 6'b000000, 6'b100000, 4'd1));
        vecs.push_back(mk(0, 6'b000000, 6'b100000, 4'd6));
        vecs.push_back(mk(0, 6'b000000, 6'b100000, 4'd7));
        vecs.push_back(mk(0, 6'b000000, 6'b001000, 4'd0));
        vecs.push_back(mk(0, 6'b000000, 6'b001000, 4'd1));
        vecs.push_back(mk(0, 6'b000000, 6'b001000, 4'd12));
        // BEQ, J
        vecs.push_back(mk(0, 6'b000100, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b000100, 6'h00, 4'd1));
        vecs.push_back(mk(0, 6'b000100, 6'h00, 4'd8));
        vecs.push_back(mk(0, 6'b000010, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b000010, 6'h00, 4'd1));
        vecs.push_back(mk(0, 6'b000010, 6'h00, 4'd9));
        // SW, ADDI
        vecs.push_back(mk(0, 6'b101011, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b101011, 6'h00, 4'd1));
        vecs.push_back(mk(0, 6'b101011, 6'h00, 4'd2));
        vecs.push_back(mk(0, 6'b101011, 6'h00, 4'd5));
        vecs.push_back(mk(0, 6'b001000, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b001000, 6'h00, 4'd1));
        vecs.push_back(mk(0, 6'b001000, 6'h00, 4'd10));
        vecs.push_back(mk(0, 6'b001000, 6'h00, 4'd11));
        // invalid opcode
        vecs.push_back(mk(0, 6'b111111, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b111111, 6'h00, 4'd1));
        // opcode changes in R_EXEC/R_WB are ignored
        vecs.push_back(mk(0, 6'b000000, 6'h20, 4'd0));
        vecs.push_back(mk(0, 6'b000000, 6'h20, 4'd1));
        vecs.push_back(mk(0, 6'b100011, 6'h20, 4'd6));
        vecs.push_back(mk(0, 6'b101011, 6'h20, 4'd7));
        // opcode is re-sampled in MEM_ADDR: LW decode, SW at MEM_ADDR
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd1));
        vecs.push_back(mk(0, 6'b101011, 6'h00, 4'd2));
        vecs.push_back(mk(0, 6'b101011, 6'h00, 4'd5));
        // mid-LW reset in MEM_READ aborts before MEM_WB
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd1));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd2));
        vecs.push_back(mk(1, 6'b100011, 6'h00, 4'd3));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd0));
        vecs.push_back(mk(0, 6'b100011, 6'h00, 4'd1));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // LW is now in MEM_ADDR; let it complete so the sequences start at FETCH
        reset = 1'b0; opcode = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        check("lw_tail_state", {12'h0, state}, 16'd0);

        run_instr("lw",   6'b100011, 6'h00, 5, 1, 0);
        run_instr("sw",   6'b101011, 6'h00, 4, 0, 1);
        run_instr("rtyp", 6'b000000, 6'h20, 4, 1, 0);
        run_instr("addi", 6'b001000, 6'h00, 4, 1, 0);
        run_instr("beq",  6'b000100, 6'h00, 3, 0, 0);
        run_instr("j",    6'b000010, 6'h00, 3, 0, 0);
        run_instr("jr",   6'b000000, 6'h08, 3, 0, 0);
        run_instr("inv",  6'b111111, 6'h00, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
